sha256_block_padder: RTL and testbench

Upstream front-end of the Hash160 datapath. It accepts a variable-length message as a byte stream of 1..55 bytes and applies SHA-256 padding: 0x80 terminator, zero fill, and a 64-bit big-endian bit length. It then emits the resulting single 64-byte block, one byte per cycle, to the Hash160 core's byte input. Messages longer than one block are rejected with an error pulse.

---
 rtl/sha256_block_padder.sv | 63 ++++++
 tb/tb_sha256_block_padder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sha256_block_padder.sv
// sha256_block_padder: buffers a 1..55 byte message and streams one SHA-256 padded 64-byte block.
module sha256_block_padder (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_first,
  output logic       o_last,
  output logic       o_err
);
  localparam int MAX_LEN = 55;
  typedef enum logic [1:0] {ACCEPT, EMIT, DROP} state_t;
  state_t state, state_nx;
  logic [5:0] len, cnt;
  logic [7:0] mem [0:MAX_LEN-1];
  logic       err, xfer, full;
  logic [7:0] pad_byte;
  assign xfer = i_valid && o_ready;
  assign full = len == 6'(MAX_LEN);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACCEPT;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ACCEPT: state_nx = !xfer ? ACCEPT : full ? (i_last ? ACCEPT : DROP) : (i_last ? EMIT : ACCEPT);
      EMIT:   state_nx = cnt == 6'd63 ? ACCEPT : EMIT;
      DROP:   state_nx = xfer && i_last ? ACCEPT : DROP;
      default: state_nx = ACCEPT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      len <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= state == ACCEPT && xfer && full;
      if (state == ACCEPT && xfer) len <= full ? 6'd0 : len + 6'd1;
      if (state == EMIT) begin
        cnt <= cnt + 6'd1;
        if (cnt == 6'd63) len <= '0;
      end
    end
  // Message storage carries no reset; only bytes below len are ever read.
  always_ff @(posedge clk)
    if (state == ACCEPT && xfer && !full) mem[len] <= i_data;
  // Bit length L*8 <= 440: byte 62 holds bit 8 (L[5]), byte 63 holds L[4:0]<<3.
  always_comb begin
    pad_byte = cnt < len ? mem[cnt] : cnt == len ? 8'h80 : cnt == 6'd62 ? {7'b0, len[5]} :
               cnt == 6'd63 ? {len[4:0], 3'b0} : 8'h00;
    o_ready  = state != EMIT;
    o_valid  = state == EMIT;
    o_data   = o_valid ? pad_byte : 8'h00;
    o_first  = o_valid && cnt == 6'd0;
    o_last   = o_valid && cnt == 6'd63;
    o_err    = err;
  end
endmodule

// File: tb/tb_sha256_block_padder.sv
// tb_sha256_block_padder: random and directed messages checked against a queue-based padding model.
module tb_sha256_block_padder;
  logic       clk = 0, rst = 0;
  logic       i_valid = 0, i_last = 0;
  logic [7:0] i_data = 0;
  logic       o_ready, o_valid, o_first, o_last, o_err;
  logic [7:0] o_data;
  int         errors = 0, checks = 0, errs_seen = 0;
  logic [7:0] od[$];
  logic       of[$], ol[$];

  sha256_block_padder dut (.clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_first(o_first), .o_last(o_last), .o_err(o_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (o_valid) begin
        od.push_back(o_data);
        of.push_back(o_first);
        ol.push_back(o_last);
      end else chk("idle_zero", {o_data, o_first, o_last}, 0);
      if (o_err) errs_seen++;
    end

  task automatic clear_q();
    od.delete(); of.delete(); ol.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    i_valid = 1; i_data = d; i_last = l;
    while (!o_ready && n < 200) begin @(negedge clk); n++; end
    if (!o_ready) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1 i_valid = 0; i_data = 0; i_last = 0;
  endtask

  task automatic send_msg(input logic [7:0] m[$]);
    foreach (m[i]) begin
      send_byte(m[i], i == m.size() - 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic check_block(input string tag, input logic [7:0] m[$]);
    logic [7:0] e[$];
    logic [63:0] bits;
    int n = 0;
    e = m;
    e.push_back(8'h80);
    while (e.size() < 56) e.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) e.push_back(bits[8*i +: 8]);
    do begin @(posedge clk); #2; n++; end while (!(od.size() >= 64 && !o_valid) && n < 150);
    chk({tag, "_count"}, od.size(), 64);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), i < od.size() ? {24'b0, od[i]} : 32'hxxxxxxxx, {24'b0, e[i]});
      chk($sformatf("%s_first%0d", tag, i), i < of.size() ? 32'(of[i]) : 32'hx, 32'(i == 0));
      chk($sformatf("%s_last%0d", tag, i), i < ol.size() ? 32'(ol[i]) : 32'hx, 32'(i == 63));
    end
    clear_q();
  endtask

  initial begin
    logic [7:0] m[$];
    int e0;
    #1 rst = 1;
    #2;
    chk("rst_ready", o_ready, 1);
    chk("rst_outs", {o_valid, o_data, o_first, o_last, o_err}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;

    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m); check_block("abc", m);
    m = '{8'h00};
    send_msg(m); check_block("zero1", m);
    m.delete(); repeat (55) m.push_back(8'hAA);
    e0 = errs_seen;
    send_msg(m); check_block("aa55", m);
    chk("aa55_noerr", errs_seen - e0, 0);

    e0 = errs_seen;
    m.delete(); repeat (56) m.push_back(8'h5C);
    send_msg(m);
    repeat (70) @(negedge clk);
    chk("len56_err", errs_seen - e0, 1);
    chk("len56_novalid", od.size(), 0);
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m); check_block("abc_after56", m);

    e0 = errs_seen;
    for (int i = 1; i <= 60; i++) begin
      send_byte(8'(i), i == 60);
      if (i == 56) begin @(negedge clk); #1 chk("drop_err_at56", errs_seen - e0, 1); end
    end
    repeat (70) @(negedge clk);
    chk("drop_err_once", errs_seen - e0, 1);
    chk("drop_novalid", od.size(), 0);
    m = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    send_msg(m); check_block("after_drop", m);

    m = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_msg(m);
    repeat (20) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ready", o_ready, 1);
    chk("midrst_outs", {o_data, o_first, o_last, o_err}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    clear_q();
    m = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h42};
    send_msg(m); check_block("after_rst", m);

    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m);
    @(negedge clk);
    i_valid = 1; i_data = 8'hEE; i_last = 1;
    for (int n = 0; n < 100 && !o_ready; n++) @(negedge clk);
    i_valid = 0; i_data = 0; i_last = 0;
    check_block("stall_abc", m);
    m = '{8'h78, 8'h79};
    send_msg(m); check_block("stall_next", m);

    for (int t = 0; t < 6; t++) begin
      m.delete();
      repeat ($urandom_range(1, 55)) m.push_back(8'($urandom));
      send_msg(m); check_block($sformatf("rand%0d", t), m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
